// File: rtl/fault_campaign_ctrl_if.sv
// Bundle between the campaign sequencer (master) and the config/DUT side (slave).
// Latency: none, wires only. Backpressure: none; start is a one-cycle request.
// FN_LOG_EN adds the first-false-negative capture signals.
interface fault_campaign_ctrl_if #(
    parameter int NG    = 128,
    parameter int GW    = 7,
    parameter int W     = 4,
    parameter int CNT_W = 16
);
    logic             start;
    logic [GW-1:0]    gid_first;
    logic [GW-1:0]    gid_last;
    logic             cin_cfg;
    logic             busy;
    logic             done;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             Cin;
    logic [1:0]       A_mod3;
    logic [1:0]       B_mod3;
    logic [NG-1:0]    fault_en_bus;
    logic             fault_val;
    logic [W:0]       sout;
    logic             err;
    logic [CNT_W-1:0] tp;
    logic [CNT_W-1:0] tn;
    logic [CNT_W-1:0] fp;
    logic [CNT_W-1:0] fn;
`ifdef FN_LOG_EN
    logic             fn_seen;
    logic [GW-1:0]    fn_gid;
    logic             fn_sa;
    logic [W-1:0]     fn_a;
    logic [W-1:0]     fn_b;
    logic [W:0]       fn_sout;
`endif

    modport master (
        input  start, gid_first, gid_last, cin_cfg, sout, err,
        output busy, done, A, B, Cin, A_mod3, B_mod3, fault_en_bus, fault_val,
               tp, tn, fp, fn
`ifdef FN_LOG_EN
        , output fn_seen, fn_gid, fn_sa, fn_a, fn_b, fn_sout
`endif
    );

    modport slave (
        output start, gid_first, gid_last, cin_cfg, sout, err,
        input  busy, done, A, B, Cin, A_mod3, B_mod3, fault_en_bus, fault_val,
               tp, tn, fp, fn
`ifdef FN_LOG_EN
        , input fn_seen, fn_gid, fn_sa, fn_a, fn_b, fn_sout
`endif
    );
endinterface

// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer with TP/TN/FP/FN counters; FN_LOG_EN keeps the first FN.
// Latency: one vector every SETTLE+1 cycles; done rises the cycle after the last SAMPLE.
// Backpressure: none; start is ignored while busy.
module fault_campaign_ctrl #(
    parameter int NG     = 128,
    parameter int GW     = 7,
    parameter int W      = 4,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst,
    fault_campaign_ctrl_if.master bus
);
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t           state_q, state_d;
    logic [SCW-1:0]   settle_q, settle_d;
    logic [GW-1:0]    gid_q, gid_d, last_q, last_d, last_in;
    logic             cin_q, cin_d, golden_q, golden_d, sa_q, sa_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [1:0]       am3_q, am3_d, bm3_q, bm3_d;
    logic [NG-1:0]    fen_q, fen_d;
    logic             fval_q, fval_d, busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0] tp_q, tp_d, tn_q, tn_d, fp_q, fp_d, fn_q, fn_d;
    logic [W:0]       ref_sum;
    logic             mismatch, last_vec, run;
`ifdef FN_LOG_EN
    logic             fn_seen_q, fn_seen_d, fn_sa_q, fn_sa_d;
    logic [GW-1:0]    fn_gid_q, fn_gid_d;
    logic [W-1:0]     fn_a_q, fn_a_d, fn_b_q, fn_b_d;
    logic [W:0]       fn_sout_q, fn_sout_d;
`endif

    function automatic logic [1:0] mod3(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v % W'(3);
        return r[1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Out-of-range last GID is clamped so the one-hot never runs off the bus.
    assign last_in  = ({1'b0, bus.gid_last} >= (GW+1)'(NG)) ? GW'(NG-1) : bus.gid_last;
    assign ref_sum  = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};
    assign mismatch = (bus.sout != ref_sum);
    assign last_vec = (&a_q) && (&b_q) && (golden_q || (sa_q && gid_q == last_q));

    always_comb begin
        state_d  = state_q;  settle_d = settle_q; gid_d  = gid_q;  last_d = last_q;
        cin_d    = cin_q;    golden_d = golden_q; sa_d   = sa_q;   a_d    = a_q;
        b_d      = b_q;      busy_d   = busy_q;   done_d = done_q;
        tp_d     = tp_q;     tn_d     = tn_q;     fp_d   = fp_q;   fn_d   = fn_q;
`ifdef FN_LOG_EN
        fn_seen_d = fn_seen_q; fn_gid_d = fn_gid_q; fn_sa_d   = fn_sa_q;
        fn_a_d    = fn_a_q;    fn_b_d   = fn_b_q;   fn_sout_d = fn_sout_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    gid_d    = bus.gid_first;
                    last_d   = last_in;
                    golden_d = (bus.gid_first > last_in);
                    cin_d    = bus.cin_cfg;
                    sa_d = 1'b0; a_d = '0; b_d = '0; settle_d = '0;
                    tp_d = '0; tn_d = '0; fp_d = '0; fn_d = '0;
                    busy_d = 1'b1; done_d = 1'b0; state_d = APPLY;
`ifdef FN_LOG_EN
                    fn_seen_d = 1'b0; fn_gid_d = '0; fn_sa_d = 1'b0;
                    fn_a_d = '0; fn_b_d = '0; fn_sout_d = '0;
`endif
                end
            end
            APPLY: begin
                if (settle_q == SCW'(SETTLE-1)) state_d = SAMPLE;
                else                            settle_d = settle_q + 1'b1;
            end
            SAMPLE: begin
                settle_d = '0;
                if (mismatch) begin
                    if (bus.err) tp_d = sat_inc(tp_q);
                    else         fn_d = sat_inc(fn_q);
                end else begin
                    if (bus.err) fp_d = sat_inc(fp_q);
                    else         tn_d = sat_inc(tn_q);
                end
`ifdef FN_LOG_EN
                if (mismatch && !bus.err && !fn_seen_q) begin
                    fn_seen_d = 1'b1; fn_gid_d = gid_q; fn_sa_d = sa_q;
                    fn_a_d = a_q; fn_b_d = b_q; fn_sout_d = bus.sout;
                end
`endif
                if (last_vec) begin
                    state_d = DONE; busy_d = 1'b0; done_d = 1'b1;
                end else begin
                    state_d = APPLY;
                    b_d = b_q + 1'b1;
                    if (&b_q) begin
                        a_d = a_q + 1'b1;
                        if (&a_q) begin
                            sa_d = ~sa_q;
                            if (sa_q) gid_d = gid_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are derived from next-state values so mod3 and fault lines move with A/B.
        run    = (state_d == APPLY) || (state_d == SAMPLE);
        fen_d  = (run && !golden_d) ? (NG'(1) << gid_d) : '0;
        fval_d = run && !golden_d && sa_d;
        am3_d  = mod3(a_d);
        bm3_d  = mod3(b_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;  settle_q <= '0;   gid_q <= '0;   last_q <= '0;
            cin_q   <= 1'b0;  golden_q <= 1'b0; sa_q  <= 1'b0; a_q    <= '0;
            b_q     <= '0;    am3_q    <= '0;   bm3_q <= '0;   fen_q  <= '0;
            fval_q  <= 1'b0;  busy_q   <= 1'b0; done_q <= 1'b0;
            tp_q <= '0; tn_q <= '0; fp_q <= '0; fn_q <= '0;
`ifdef FN_LOG_EN
            fn_seen_q <= 1'b0; fn_gid_q <= '0; fn_sa_q <= 1'b0;
            fn_a_q <= '0; fn_b_q <= '0; fn_sout_q <= '0;
`endif
        end else begin
            state_q <= state_d; settle_q <= settle_d; gid_q <= gid_d;  last_q <= last_d;
            cin_q   <= cin_d;   golden_q <= golden_d; sa_q  <= sa_d;   a_q    <= a_d;
            b_q     <= b_d;     am3_q    <= am3_d;    bm3_q <= bm3_d;  fen_q  <= fen_d;
            fval_q  <= fval_d;  busy_q   <= busy_d;   done_q <= done_d;
            tp_q <= tp_d; tn_q <= tn_d; fp_q <= fp_d; fn_q <= fn_d;
`ifdef FN_LOG_EN
            fn_seen_q <= fn_seen_d; fn_gid_q <= fn_gid_d; fn_sa_q <= fn_sa_d;
            fn_a_q <= fn_a_d; fn_b_q <= fn_b_d; fn_sout_q <= fn_sout_d;
`endif
        end
    end

    assign bus.busy = busy_q;   assign bus.done = done_q;
    assign bus.A = a_q;         assign bus.B = b_q;       assign bus.Cin = cin_q;
    assign bus.A_mod3 = am3_q;  assign bus.B_mod3 = bm3_q;
    assign bus.fault_en_bus = fen_q;
    assign bus.fault_val = fval_q;
    assign bus.tp = tp_q; assign bus.tn = tn_q; assign bus.fp = fp_q; assign bus.fn = fn_q;
`ifdef FN_LOG_EN
    assign bus.fn_seen = fn_seen_q; assign bus.fn_gid = fn_gid_q; assign bus.fn_sa = fn_sa_q;
    assign bus.fn_a = fn_a_q;       assign bus.fn_b = fn_b_q;     assign bus.fn_sout = fn_sout_q;
`endif
endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Bench for fault_campaign_ctrl: stubbed residue-checked adder plus a loop-based campaign model.
module tb_fault_campaign_ctrl;
    localparam int NG = 128, GW = 7, W = 4, SETTLE = 2, CNT_W = 16;
    localparam int NV = 1 << (2*W);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   mode = 0;   // 0 ideal, 1 stuck bit0 err=0, 2 stuck bit0 err=compare, 3 err stuck high
    int   sg = 0;     // GID the stub reacts to
    logic [W:0] stub_ref;

    always #5 clk = ~clk;

    fault_campaign_ctrl_if #(.NG(NG), .GW(GW), .W(W), .CNT_W(CNT_W)) bus ();

    fault_campaign_ctrl #(.NG(NG), .GW(GW), .W(W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always_comb begin
        stub_ref = {1'b0, bus.A} + {1'b0, bus.B} + {{W{1'b0}}, bus.Cin};
        bus.sout = stub_ref;
        if ((mode == 1 || mode == 2) && bus.fault_en_bus[sg]) bus.sout[0] = bus.fault_val;
        bus.err = (mode == 3) || (mode == 2 && bus.sout != stub_ref);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: walk every (gid, stuck value, A, B) tuple and classify by the rules directly.
    int e_tp, e_tn, e_fp, e_fn, e_cyc, e_fseen, e_fgid, e_fsa, e_fa, e_fb, e_fsout;
    task automatic model(input int first, input int last, input int cin);
        int l, ngid, nsa, g, rs, so, e;
        bit golden, act;
        l = (last > NG-1) ? NG-1 : last;
        golden = first > l;
        ngid = golden ? 1 : l - first + 1;
        nsa  = golden ? 1 : 2;
        e_tp = 0; e_tn = 0; e_fp = 0; e_fn = 0; e_fseen = 0;
        e_fgid = 0; e_fsa = 0; e_fa = 0; e_fb = 0; e_fsout = 0;
        for (int gi = 0; gi < ngid; gi++)
            for (int s = 0; s < nsa; s++)
                for (int a = 0; a < (1 << W); a++)
                    for (int b = 0; b < (1 << W); b++) begin
                        g   = first + gi;
                        act = !golden && g == sg && (mode == 1 || mode == 2);
                        rs  = a + b + cin;
                        so  = act ? ((rs & ~1) | s) : rs;
                        e   = (mode == 3) || (mode == 2 && so != rs);
                        if (so != rs && e != 0) e_tp++;
                        else if (so != rs) begin
                            e_fn++;
                            if (e_fseen == 0) begin
                                e_fseen = 1; e_fgid = g; e_fsa = s; e_fa = a; e_fb = b; e_fsout = so;
                            end
                        end
                        else if (e != 0) e_fp++;
                        else e_tn++;
                    end
        e_cyc = ngid * nsa * NV * (SETTLE + 1);
    endtask

    // One full campaign; inject >= 0 pulses start (with scrambled config) at that cycle.
    task automatic run_campaign(input int first, input int last, input int cin, input int inject);
        int cyc, bad, v, ea, eb, es, eg;
        bit golden;
        logic [NG-1:0] one, efen;
        one = 1;
        model(first, last, cin);
        golden = first > last;
        @(negedge clk);
        bus.gid_first = GW'(first); bus.gid_last = GW'(last); bus.cin_cfg = cin[0];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_clears_done", bus.done, 0);
        chk("start_clears_cnt", {bus.tp, bus.tn, bus.fp, bus.fn}, 0);
        cyc = 0; bad = 0;
        while (!bus.done && cyc < e_cyc + 20) begin
            v  = cyc / (SETTLE + 1);
            eb = v % (1 << W);
            ea = (v / (1 << W)) % (1 << W);
            es = golden ? 0 : (v / NV) % 2;
            eg = first + (golden ? 0 : v / (2 * NV));
            efen = golden ? '0 : (one << eg);
            if (bus.busy !== 1'b1 || bus.A !== W'(ea) || bus.B !== W'(eb) || bus.Cin !== cin[0]
                || bus.A_mod3 !== 2'(ea % 3) || bus.B_mod3 !== 2'(eb % 3)
                || bus.fault_en_bus !== efen || bus.fault_val !== es[0]) bad++;
            if (cyc == inject) begin
                bus.start = 1'b1; bus.gid_first = GW'($urandom); bus.gid_last = GW'($urandom);
                bus.cin_cfg = ~cin[0];
            end
            if (cyc == inject + 1) bus.start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk("cycles", cyc, e_cyc);
        chk("vector_stream_bad", bad, 0);
        chk("tp", bus.tp, e_tp);
        chk("tn", bus.tn, e_tn);
        chk("fp", bus.fp, e_fp);
        chk("fn", bus.fn, e_fn);
        chk("done_idle_outs", {bus.busy, bus.fault_val, bus.fault_en_bus}, 0);
`ifdef FN_LOG_EN
        chk("fn_seen", bus.fn_seen, e_fseen);
        if (e_fseen != 0)
            chk("fn_log", {bus.fn_gid, bus.fn_sa, bus.fn_a, bus.fn_b, bus.fn_sout},
                {GW'(e_fgid), 1'(e_fsa), W'(e_fa), W'(e_fb), (W+1)'(e_fsout)});
`endif
        repeat (3) @(negedge clk);
        chk("done_held", bus.done, 1);
        chk("cnt_hold", {bus.tp, bus.tn, bus.fp, bus.fn},
            {CNT_W'(e_tp), CNT_W'(e_tn), CNT_W'(e_fp), CNT_W'(e_fn)});
    endtask

    initial begin
        int f, l;
        bus.start = 1'b0; bus.gid_first = '0; bus.gid_last = '0; bus.cin_cfg = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_status", {bus.busy, bus.done, bus.fault_val}, 0);
        chk("rst_operands", {bus.A, bus.B, bus.Cin, bus.A_mod3, bus.B_mod3}, 0);
        chk("rst_fault_en", bus.fault_en_bus, 0);
        chk("rst_counters", {bus.tp, bus.tn, bus.fp, bus.fn}, 0);

        mode = 0; sg = 0;  run_campaign(1, 0, 0, -1);      // golden pass
        mode = 1; sg = 0;  run_campaign(0, 0, 0, -1);      // silent stuck-at
        mode = 2; sg = 0;  run_campaign(0, 0, 1, -1);      // detected stuck-at
        mode = 3; sg = 0;  run_campaign(20, 23, 0, -1);    // always-on checker
        mode = 1; sg = 40; run_campaign(40, 40, 1, 700);   // start pulse while busy

        // Reset in the middle of a campaign, then rerun it from scratch.
        mode = 3;
        @(negedge clk);
        bus.gid_first = 7'd5; bus.gid_last = 7'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_status", {bus.busy, bus.done, bus.fault_val}, 0);
        chk("midrst_counters", {bus.tp, bus.tn, bus.fp, bus.fn}, 0);
        chk("midrst_bus", {bus.fault_en_bus, bus.A, bus.B}, 0);
        run_campaign(5, 5, 1, -1);

        for (int r = 0; r < 4; r++) begin
            f    = $urandom_range(1, NG - 2);
            l    = (r == 3) ? f - 1 : f + int'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            sg   = f + int'($urandom_range(0, 1));
            run_campaign(f, l, $urandom_range(0, 1), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fault_campaign_ctrl.md
Name: fault_campaign_ctrl

Overview:
Synthesizable fault-injection campaign sequencer for the residue-checked RCA datapath (RCA, residue_mod3, adder_mod3, mod3_comparator).
- Drives operands, reference residues and the one-hot fault_en_bus / fault_val pair.
- Samples the checker's Sout/err after a settle window, classifies each vector as TP/TN/FP/FN and accumulates the counts.
- Lets the fault-coverage campaign run in hardware (FPGA) instead of only in simulation; sits between the configuration registers and the fault-instrumented DUT.

Parameters:
NG, 128, number of fault GIDs; width of fault_en_bus.
GW, 7, GID index width (>= clog2(NG)).
W, 4, operand width of A/B.
SETTLE, 2, cycles between applying a vector and sampling it (min 1).
CNT_W, 16, width of each TP/TN/FP/FN counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle campaign start request
gid_first  in  GW  first GID of range; latched on accepted start
gid_last  in  GW  last GID of range; latched; gid_first > gid_last means fault-free golden pass
cin_cfg  in  1  carry-in used for the whole campaign; latched on start
busy  out  1  campaign running
done  out  1  campaign finished; held until next accepted start
A  out  W  operand A to DUT
B  out  W  operand B to DUT
Cin  out  1  carry-in to DUT
A_mod3  out  2  A % 3
B_mod3  out  2  B % 3
fault_en_bus  out  NG  one-hot fault enable; all-zero in golden pass and when idle
fault_val  out  1  stuck-at value (0 then 1)
sout  in  W+1  DUT sum {Cout,S}
err  in  1  checker error flag
tp, tn, fp, fn  out  CNT_W each  classification counters

Behaviour:
- Reset (any cycle, including mid-campaign): state IDLE; busy=0, done=0; A=B=0, Cin=0, A_mod3=B_mod3=0; fault_en_bus=0, fault_val=0; all counters 0.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE/DONE + start=1:
  - latch gid_first, gid_last, cin_cfg;
  - clear counters, clear done;
  - gid=gid_first, sa=0, A=0, B=0;
  - go to APPLY; busy=1 from the next cycle.
- start while busy is ignored.
- APPLY: outputs registered and stable; stays SETTLE cycles, then SAMPLE.
- SAMPLE (1 cycle):
  - ref = A + B + Cin, computed at W+1 bits, no overflow loss.
  - Classify:
    - sout != ref and err=1: TP
    - sout != ref and err=0: FN
    - sout == ref and err=1: FP
    - sout == ref and err=0: TN
  - Increment exactly one counter; counters saturate at all-ones.
  - Then advance and return to APPLY. The new vector appears on the outputs the cycle after SAMPLE.
  - Vector period = SETTLE+1 cycles.
- Iteration order, innermost first:
  1. B 0..2^W-1
  2. A 0..2^W-1
  3. sa 0..1
  4. gid gid_first..gid_last
- fault_val = sa; fault_en_bus = one-hot at gid.
- On the final vector's SAMPLE, go to DONE: busy=0, done=1, fault_en_bus=0, fault_val=0, counters hold.
- Golden pass: one sweep of A,B only (2^(2W) vectors), fault_en_bus=0, fault_val=0.
- A_mod3/B_mod3 are registered together with A/B, never a cycle behind.
- gid_last >= NG: clamp to NG-1 at latch time.
- Total campaign cycles: (gid_last-gid_first+1) * 2 * 2^(2W) * (SETTLE+1); golden pass 2^(2W) * (SETTLE+1).

Optional Feature:
FN_LOG_EN
- Defined: adds outputs
  - fn_seen (1)
  - fn_gid (GW)
  - fn_sa (1)
  - fn_a (W)
  - fn_b (W)
  - fn_sout (W+1)
- These capture the first FN event of the campaign (first only, later FNs ignored) and are cleared on reset and on accepted start.
- Undefined: ports and logic absent; counters unchanged.

Test Plan:
- Golden pass, W=4, SETTLE=2, gid_first=1, gid_last=0, ideal DUT stub (sout=A+B+Cin, err=0) -> tn=256, tp=fp=fn=0, done high exactly 768 cycles after start accepted, fault_en_bus=0 throughout.
- Range 0..0, stub forcing sout[0]=fault_val when fault_en_bus[0], err=0 -> fn=256, tn=256; FN_LOG_EN: fn_gid=0, fn_sa=0, fn_a=0, fn_b=1, fn_sout=0.
- Same stub, comparator-like err = (sout != A+B+Cin) -> tp=256, tn=256, fn=0.
- Stub err=1 always, range 20..23 -> fp=2048, tp=tn=fn=0; fault_en_bus one-hot stepping bits 20->23, fault_val toggling 0->1 per GID.
- Assert rst mid-campaign (after 100 cycles) -> next cycle busy=0, done=0, counters=0, fault_en_bus=0; new start runs the full campaign again.
- Pulse start while busy -> ignored, counts and total cycle count match the undisturbed run; start after done clears done and counters.
